// File: rtl/fadd_align_stage.sv
// ============================================================================
// fadd_align_stage
// ----------------------------------------------------------------------------
// Operand-alignment front end for the single-precision adder fadd_single.
// It accepts an IEEE-754 single-precision operand pair on a valid/ready
// handshake and unpacks both operands. It orders them by effective exponent
// and right-shifts the smaller operand's mantissa into alignment, keeping
// guard, round and sticky bits. The aligned pair is then held until the
// downstream logic takes it.
//
// Build option:
//   FADD_ALIGN_BARREL_EN  defined   -> single-cycle barrel shift at accept;
//                                      there is no ALIGN state.
//                         undefined -> iterative shifter, one bit per cycle.
//   Both builds produce bit-identical results.
//
// Ports:
//   clk            clock; all state updates on its rising edge
//   rst            asynchronous active-high reset
//   a, b           operands (IEEE-754 single)
//   in_valid       operand pair valid
//   in_ready       stage can accept a pair (IDLE only)
//   out_valid      aligned result valid (HOLD only)
//   out_ready      downstream accepts the result
//   out_sign_big   sign of the larger-exponent operand
//   out_sign_small sign of the smaller-exponent operand
//   out_exp        common (larger) biased exponent; 255 for specials
//   out_man_big    {hidden, frac[22:0], G, R, S} of the big operand
//   out_man_small  aligned {hidden, frac[22:0], G, R, S} of the small operand
//   out_inf        result is an infinity
//   out_nan        result is NaN (NaN input, or +Inf added to -Inf)
// ============================================================================
module fadd_align_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign_big,
    output logic        out_sign_small,
    output logic [7:0]  out_exp,
    output logic [26:0] out_man_big,
    output logic [26:0] out_man_small,
    output logic        out_inf,
    output logic        out_nan
);

`ifdef FADD_ALIGN_BARREL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Unpack and order the incoming pair (only used on the accept edge)
    // ------------------------------------------------------------------
    logic [7:0]  exp_a, exp_b;
    logic        hid_a, hid_b;
    logic [7:0]  eff_a, eff_b;
    logic [26:0] man_a, man_b;
    logic        a_big;
    logic [7:0]  exp_big_d, exp_small_d, exp_diff_d;
    logic [4:0]  shamt_d;
    logic [26:0] man_big_d, man_small_d;
    logic        sign_big_d, sign_small_d;
    logic        inf_a, inf_b, nan_a, nan_b;
    logic        special_d, nan_d;

    assign exp_a = a[30:23];
    assign exp_b = b[30:23];
    assign hid_a = (exp_a != 8'd0);
    assign hid_b = (exp_b != 8'd0);
    // Subnormals share the weight of exponent 1.
    assign eff_a = hid_a ? exp_a : 8'd1;
    assign eff_b = hid_b ? exp_b : 8'd1;
    assign man_a = {hid_a, a[22:0], 3'b000};
    assign man_b = {hid_b, b[22:0], 3'b000};

    // Ties go to a.
    assign a_big        = (eff_a >= eff_b);
    assign exp_big_d    = a_big ? eff_a : eff_b;
    assign exp_small_d  = a_big ? eff_b : eff_a;
    assign man_big_d    = a_big ? man_a : man_b;
    assign man_small_d  = a_big ? man_b : man_a;
    assign sign_big_d   = a_big ? a[31] : b[31];
    assign sign_small_d = a_big ? b[31] : a[31];
    assign exp_diff_d   = exp_big_d - exp_small_d;
    // Beyond 27 positions every mantissa bit lands in sticky anyway.
    assign shamt_d      = (exp_diff_d > 8'd27) ? 5'd27 : exp_diff_d[4:0];

    assign inf_a     = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
    assign inf_b     = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
    assign nan_a     = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
    assign nan_b     = (exp_b == 8'hFF) && (b[22:0] != 23'd0);
    assign special_d = (exp_a == 8'hFF) || (exp_b == 8'hFF);
    assign nan_d     = nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]));

`ifdef FADD_ALIGN_BARREL_EN
    // Barrel shift: bits shifted out are ORed into the new bit 0. When
    // shamt is 27 the shifted 1 falls off the top, so the mask becomes all
    // ones and every bit is folded into sticky.
    logic [26:0] shift_mask_d;
    logic [26:0] man_shift_d;
    assign shift_mask_d = (27'd1 << shamt_d) - 27'd1;
    assign man_shift_d  = (man_small_d >> shamt_d)
                        | {26'd0, |(man_small_d & shift_mask_d)};
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        sign_big_q, sign_small_q;
    logic [7:0]  exp_q;
    logic [26:0] man_big_q, man_small_q;
    logic        inf_q, nan_q;
`ifndef FADD_ALIGN_BARREL_EN
    logic [4:0]  cnt_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            exp_q        <= 8'd0;
            man_big_q    <= 27'd0;
            man_small_q  <= 27'd0;
            inf_q        <= 1'b0;
            nan_q        <= 1'b0;
`ifndef FADD_ALIGN_BARREL_EN
            cnt_q        <= 5'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_big_q   <= sign_big_d;
                        sign_small_q <= sign_small_d;
                        man_big_q    <= man_big_d;
                        if (special_d) begin
                            // Specials bypass alignment entirely.
                            exp_q       <= 8'hFF;
                            man_small_q <= man_small_d;
                            nan_q       <= nan_d;
                            inf_q       <= !nan_d;
                            state_q     <= S_HOLD;
                        end else begin
                            exp_q <= exp_big_d;
                            nan_q <= 1'b0;
                            inf_q <= 1'b0;
`ifdef FADD_ALIGN_BARREL_EN
                            man_small_q <= man_shift_d;
                            state_q     <= S_HOLD;
`else
                            man_small_q <= man_small_d;
                            cnt_q       <= shamt_d;
                            state_q     <= (shamt_d == 5'd0) ? S_HOLD : S_ALIGN;
`endif
                        end
                    end
                end
`ifndef FADD_ALIGN_BARREL_EN
                S_ALIGN: begin
                    // One-bit right shift; the new bit 0 keeps the sticky OR.
                    man_small_q <= {1'b0, man_small_q[26:2],
                                    man_small_q[1] | man_small_q[0]};
                    cnt_q       <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_sign_big   = sign_big_q;
    assign out_sign_small = sign_small_q;
    assign out_exp        = exp_q;
    assign out_man_big    = man_big_q;
    assign out_man_small  = man_small_q;
    assign out_inf        = inf_q;
    assign out_nan        = nan_q;

endmodule

// File: tb/tb_fadd_align_stage.sv
// ============================================================================
// tb_fadd_align_stage
// ----------------------------------------------------------------------------
// Self-checking bench for fadd_align_stage. It applies a table of directed
// vectors, randomized pairs checked against an arithmetic reference model,
// and hand-written sequences for backpressure and reset during alignment.
// ============================================================================
module tb_fadd_align_stage;

`ifdef FADD_ALIGN_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_big, out_sign_small;
    logic [7:0]  out_exp;
    logic [26:0] out_man_big, out_man_small;
    logic        out_inf, out_nan;

    fadd_align_stage dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sign_big   (out_sign_big),
        .out_sign_small (out_sign_small),
        .out_exp        (out_exp),
        .out_man_big    (out_man_big),
        .out_man_small  (out_man_small),
        .out_inf        (out_inf),
        .out_nan        (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sb;
        logic        ss;
        logic [7:0]  ex;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        inf;
        logic        nan;
        int          lat;   // latency of the iterative build
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: works on the numeric values of the mantissas rather
    // than bit-level shifting. Alignment is integer division by 2^d, and any
    // nonzero remainder sets the sticky LSB.
    function automatic vec_t ref_model(input logic [31:0] ra, input logic [31:0] rb);
        vec_t   v;
        int     ea, eb, effa, effb, d;
        longint ma, mb, mbig, msmall, pw;
        bit     a_is_big, fa0, fb0;
        v.a = ra;
        v.b = rb;
        ea = int'(ra[30:23]);
        eb = int'(rb[30:23]);
        fa0 = (ra[22:0] == 0);
        fb0 = (rb[22:0] == 0);
        effa = (ea == 0) ? 1 : ea;
        effb = (eb == 0) ? 1 : eb;
        ma = ((ea != 0) ? 64'd67108864 : 64'd0) + longint'(ra[22:0]) * 8;
        mb = ((eb != 0) ? 64'd67108864 : 64'd0) + longint'(rb[22:0]) * 8;
        a_is_big = (effa >= effb);
        mbig   = a_is_big ? ma : mb;
        msmall = a_is_big ? mb : ma;
        v.sb = a_is_big ? ra[31] : rb[31];
        v.ss = a_is_big ? rb[31] : ra[31];
        v.mb = mbig[26:0];
        d = a_is_big ? (effa - effb) : (effb - effa);
        if (d > 27) d = 27;
        if (ea == 255 || eb == 255) begin
            v.nan = (ea == 255 && !fa0) || (eb == 255 && !fb0) ||
                    (ea == 255 && eb == 255 && ra[31] != rb[31]);
            v.inf = !v.nan;
            v.ex  = 8'hFF;
            v.ms  = msmall[26:0];
            v.lat = 1;
        end else begin
            pw = 64'd1 << d;
            msmall = (msmall / pw) | ((msmall % pw) != 0 ? 64'd1 : 64'd0);
            v.nan = 1'b0;
            v.inf = 1'b0;
            v.ex  = a_is_big ? 8'(effa) : 8'(effb);
            v.ms  = msmall[26:0];
            v.lat = 1 + d;
        end
        return v;
    endfunction

    // One full transaction: present, accept, wait for HOLD, check, drain.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        int req_lat;
        req_lat = BARREL ? 1 : v.lat;
        @(negedge clk);
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"},  32'(lat), 32'(req_lat));
        chk({tag, ".exp"},      32'(out_exp), 32'(v.ex));
        chk({tag, ".man_big"},  32'(out_man_big), 32'(v.mb));
        chk({tag, ".man_small"},32'(out_man_small), 32'(v.ms));
        chk({tag, ".flags"},    {28'd0, out_sign_big, out_sign_small, out_inf, out_nan},
                                {28'd0, v.sb, v.ss, v.inf, v.nan});
        chk({tag, ".in_ready_hold"}, 32'(in_ready), 32'd0);
        $display("txn %0d %s a=%h b=%h exp=%h mb=%h ms=%h inf=%0d nan=%0d lat=%0d",
                 n_txn, tag, v.a, v.b, out_exp, out_man_big, out_man_small,
                 out_inf, out_nan, lat);
        n_txn++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        //        a             b             sb    ss    ex     mb            ms            inf   nan   lat
        tbl[0] = '{32'h40100007, 32'h41F00003, 1'b0, 1'b0, 8'h83, 27'h7800018, 27'h0900007, 1'b0, 1'b0, 4};
        tbl[1] = '{32'h3F800000, 32'hBFC00000, 1'b0, 1'b1, 8'h7F, 27'h4000000, 27'h6000000, 1'b0, 1'b0, 1};
        tbl[2] = '{32'h3F800000, 32'h4F800000, 1'b0, 1'b0, 8'h9F, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 28};
        tbl[3] = '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 1};
        tbl[4] = '{32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1};
        tbl[5] = '{32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 27'h6000000, 27'h4000000, 1'b0, 1'b1, 1};
        tbl[6] = '{32'h00000001, 32'h00800000, 1'b0, 1'b0, 8'h01, 27'h0000008, 27'h4000000, 1'b0, 1'b0, 1};
        tbl[7] = '{32'h3F800000, 32'hC0000000, 1'b1, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 2};

        rst = 1'b1;
        a = 32'd0;
        b = 32'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset.in_ready",  32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.outputs",   {out_sign_big, out_sign_small, out_inf, out_nan, out_exp,
                                out_man_big | out_man_small},
                               32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Randomized pairs against the reference model
        for (int i = 0; i < 40; i++) begin
            int ea, eb;
            logic [31:0] ra, rb;
            ea = $urandom_range(0, 254);
            if (i % 2 == 0) begin
                eb = ea + int'($urandom_range(0, 20)) - 10;
                if (eb < 0) eb = 0;
                if (eb > 254) eb = 254;
            end else begin
                eb = $urandom_range(0, 254);
            end
            if (i % 10 == 3) ea = 255;
            if (i % 13 == 5) eb = 255;
            ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if (i % 20 == 3) ra[22:0] = 23'd0;
            rv = ref_model(ra, rb);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Backpressure: HOLD with out_ready low while another pair waits
        @(negedge clk);
        a = tbl[0].a;
        b = tbl[0].b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = tbl[1].a;
        b = tbl[1].b;
        for (int k = 0; k < 40 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready",  32'(in_ready), 32'd0);
            chk("bp.man_small", 32'(out_man_small), 32'h0900007);
            chk("bp.exp",       32'(out_exp), 32'h83);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.release_valid", 32'(out_valid), 32'd0);
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.pending_accepted", 32'(in_ready), 32'd0);
        chk("bp.pending_valid",    32'(out_valid), 32'd1);
        chk("bp.pending_man_small",32'(out_man_small), 32'h6000000);
        chk("bp.pending_sign_small",32'(out_sign_small), 32'd1);
        $display("txn %0d backpressure a=%h b=%h ms=%h", n_txn, tbl[1].a, tbl[1].b, out_man_small);
        n_txn++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into the d = 3 alignment
        @(negedge clk);
        a = tbl[0].a;
        b = tbl[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.man_small", 32'(out_man_small), 32'd0);
        chk("rst.man_big",   32'(out_man_big), 32'd0);
        chk("rst.exp",       32'(out_exp), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 35; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) pulses++;
            end
            chk("rst.no_valid_pulse", 32'(pulses), 32'd0);
            chk("rst.in_ready_after", 32'(in_ready), 32'd1);
        end
        $display("txn %0d reset_mid_align a=%h b=%h", n_txn, tbl[0].a, tbl[0].b);
        n_txn++;

        // The stage must still work after the abort
        run_txn(tbl[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
